// File: rtl/wb_port_arbiter_if.sv
// Writeback-port bundle: pipeline writeback, long-latency unit results and the
// single register-file write port, plus the registered stall request.
interface wb_port_arbiter_if;
  logic        RegWriteW;
  logic [4:0]  RD_W;
  logic [31:0] ResultW;
  logic        LU_valid;
  logic [4:0]  LU_rd;
  logic [31:0] LU_data;
  logic        LU_ready;
  logic        RegWrite_RF;
  logic [4:0]  RD_RF;
  logic [31:0] WD_RF;
  logic        StallReq;

  modport master (
    output RegWriteW, RD_W, ResultW, LU_valid, LU_rd, LU_data,
    input  LU_ready, RegWrite_RF, RD_RF, WD_RF, StallReq
  );

  modport slave (
    input  RegWriteW, RD_W, ResultW, LU_valid, LU_rd, LU_data,
    output LU_ready, RegWrite_RF, RD_RF, WD_RF, StallReq
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// Shares one register-file write port between the pipeline and a 2-deep buffer of
// mul/div results. Optional macro WB_ARB_BYPASS_EN writes an LU result straight through when idle.
module wb_port_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input logic               clk,
  input logic               rst,
  wb_port_arbiter_if.slave  bus
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  typedef struct packed {
    logic        valid;
    logic [4:0]  rd;
    logic [31:0] data;
  } entry_t;

  entry_t     fifo_q [2];
  entry_t     fifo_d [2];
  logic [1:0] count_q, count_d, midCount;
  logic [3:0] starve_q, starve_d;
  logic       stallReq_q, stallReq_d;

  logic pipeWrite, luAccept, pop, push, bypass;

  assign pipeWrite = bus.RegWriteW && (bus.RD_W != 5'd0);
  assign luAccept  = bus.LU_valid && (count_q != 2'd2);
  assign pop       = !pipeWrite && (count_q != 2'd0);
`ifdef WB_ARB_BYPASS_EN
  assign bypass    = luAccept && (count_q == 2'd0) && !pipeWrite;
`else
  assign bypass    = 1'b0;
`endif
  assign push      = luAccept && !bypass;

  assign bus.LU_ready = (count_q != 2'd2);
  assign bus.StallReq = stallReq_q;

  // Write-port grant; a killed head is still popped but writes nothing.
  always_comb begin
    bus.RegWrite_RF = 1'b0;
    bus.RD_RF       = 5'd0;
    bus.WD_RF       = 32'd0;
    if (!rst) begin
      if (pipeWrite) begin
        bus.RegWrite_RF = 1'b1;
        bus.RD_RF       = bus.RD_W;
        bus.WD_RF       = bus.ResultW;
      end else if (pop) begin
        if (fifo_q[0].valid) begin
          bus.RegWrite_RF = 1'b1;
          bus.RD_RF       = fifo_q[0].rd;
          bus.WD_RF       = fifo_q[0].data;
        end
      end else if (bypass) begin
        bus.RegWrite_RF = 1'b1;
        bus.RD_RF       = bus.LU_rd;
        bus.WD_RF       = bus.LU_data;
      end
    end
  end

  always_comb begin
    fifo_d[0] = fifo_q[0];
    fifo_d[1] = fifo_q[1];
    for (int i = 0; i < 2; i++) begin
      if (pipeWrite && (fifo_q[i].rd == bus.RD_W)) fifo_d[i].valid = 1'b0;
    end
    midCount = count_q;
    if (pop) begin
      fifo_d[0] = fifo_d[1];
      midCount  = count_q - 2'd1;
    end
    // The incoming entry is written after the kill so a same-cycle result survives.
    if (push) begin
      if (midCount == 2'd0) fifo_d[0] = '{valid: 1'b1, rd: bus.LU_rd, data: bus.LU_data};
      else                  fifo_d[1] = '{valid: 1'b1, rd: bus.LU_rd, data: bus.LU_data};
    end
    count_d = midCount + {1'b0, push};

    if (pop || (count_q == 2'd0)) starve_d = 4'd0;
    else if (starve_q < LIMIT)    starve_d = starve_q + 4'd1;
    else                          starve_d = starve_q;

    stallReq_d = (count_d == 2'd2) || (starve_d >= LIMIT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fifo_q[0]  <= '0;
      fifo_q[1]  <= '0;
      count_q    <= 2'd0;
      starve_q   <= 4'd0;
      stallReq_q <= 1'b0;
    end else begin
      fifo_q[0]  <= fifo_d[0];
      fifo_q[1]  <= fifo_d[1];
      count_q    <= count_d;
      starve_q   <= starve_d;
      stallReq_q <= stallReq_d;
    end
  end

endmodule
